// File: rtl/structs.sv
// Shared read-port bundles for the variance corner cache.
// Field widths match the default IIDW/SQDW configuration.
package structs;

    typedef struct packed {
        logic [2:0] raddr;
        logic [2:0] raddrSQ;
    } struct_varianceCache_Read_in;

    typedef struct packed {
        logic [31:0] q;
        logic [63:0] qSQ;
    } struct_varianceCache_Read_out;

endpackage

// File: rtl/variance_corner_fetch_pkg.sv
// Types and constants for the variance corner fetcher.
// Corner indices double as cache entry addresses.
package variance_corner_fetch_pkg;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        FULL
    } bankState_t;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        DRAIN,
        DONE
    } fetchState_t;

    localparam logic [2:0] TL = 3'd1;
    localparam logic [2:0] TR = 3'd2;
    localparam logic [2:0] BL = 3'd3;
    localparam logic [2:0] BR = 3'd4;

    localparam int DEFAULT_STRIDE = 321;

endpackage

// File: rtl/variance_corner_bank.sv
// Four-entry corner cache bank: one write port, two async reads.
// Addresses outside TL..BR read as zero.
module variance_corner_bank
    import variance_corner_fetch_pkg::*;
#(
    parameter int IIDW = 32,
    parameter int SQDW = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            we,
    input  logic [2:0]      waddr,
    input  logic [IIDW-1:0] wdata,
    input  logic [SQDW-1:0] wdataSQ,
    input  logic [2:0]      raddr,
    input  logic [2:0]      raddrSQ,
    output logic [IIDW-1:0] q,
    output logic [SQDW-1:0] qSQ
);

    logic [IIDW-1:0] entry   [1:4];
    logic [SQDW-1:0] entrySQ [1:4];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i <= 4; i++) begin
                entry[i]   <= '0;
                entrySQ[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= 4; i++) begin
                if (we && waddr == 3'(i)) begin
                    entry[i]   <= wdata;
                    entrySQ[i] <= wdataSQ;
                end
            end
        end
    end

    always_comb begin
        q   = '0;
        qSQ = '0;
        for (int i = 1; i <= 4; i++) begin
            if (raddr == 3'(i))
                q = entry[i];
            if (raddrSQ == 3'(i))
                qSQ = entrySQ[i];
        end
    end

endmodule

// File: rtl/variance_corner_fetch.sv
// Fetches the four window corners into a ping-pong corner cache
// and hands each filled bank to the variance calculator.
module variance_corner_fetch
    import variance_corner_fetch_pkg::*;
    import structs::*;
#(
    parameter int IIDW   = 32,
    parameter int SQDW   = 64,
    parameter int ADDRW  = 17,
    parameter int STRIDE = DEFAULT_STRIDE
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [8:0]                   win_x,
    input  logic [8:0]                   win_y,
    input  logic [8:0]                   win_w,
    input  logic [8:0]                   win_h,
    output logic                         ready,
    output logic                         valid,
    output logic                         dblBuf,
    input  logic                         taken,
    input  logic [1:0]                   bankRelease,
    output logic [ADDRW-1:0]             ii_raddr,
    output logic [ADDRW-1:0]             sq_raddr,
    output logic                         ii_rd,
    input  logic [IIDW-1:0]              ii_q,
    input  logic [SQDW-1:0]              sq_q,
    input  struct_varianceCache_Read_in  vcrA_in,
    input  struct_varianceCache_Read_in  vcrB_in,
    output struct_varianceCache_Read_out vcrA_out,
    output struct_varianceCache_Read_out vcrB_out
);

    fetchState_t      state, nextState;
    bankState_t       bankSt [2];
    logic             fillPtr;
    logic [8:0]       winX, winY, winW, winH;
    logic [ADDRW-1:0] base, hoff, offs;
    logic [1:0]       issueCnt;
    logic             wrEn;
    logic [2:0]       wrIdx;
    logic             accept;
    logic [IIDW-1:0]  aQ, bQ;
    logic [SQDW-1:0]  aQSQ, bQSQ;

    assign ready  = (state == IDLE) && (bankSt[fillPtr] == FREE);
    assign accept = start && ready;
    assign valid  = (state == DONE);
    assign dblBuf = fillPtr;
    assign ii_rd  = (state == ISSUE);

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (accept) nextState = CALC;
            CALC:    nextState = ISSUE;
            ISSUE:   if (issueCnt == 2'd3) nextState = DRAIN;
            DRAIN:   nextState = DONE;
            DONE:    if (taken) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            fillPtr  <= 1'b0;
            winX     <= '0;
            winY     <= '0;
            winW     <= '0;
            winH     <= '0;
            base     <= '0;
            hoff     <= '0;
            issueCnt <= '0;
            wrEn     <= 1'b0;
            wrIdx    <= '0;
            bankSt[0] <= FREE;
            bankSt[1] <= FREE;
        end else begin
            state <= nextState;
            if (accept) begin
                winX <= win_x;
                winY <= win_y;
                winW <= win_w;
                winH <= win_h;
            end
            if (state == CALC) begin
                base <= ADDRW'(winY) * ADDRW'(STRIDE)
                      + ADDRW'(winX);
                hoff <= ADDRW'(winH) * ADDRW'(STRIDE);
            end
            issueCnt <= (state == ISSUE) ? issueCnt + 2'd1 : 2'd0;
            // Data lags the read strobe by one cycle.
            wrEn  <= (state == ISSUE);
            wrIdx <= {1'b0, issueCnt} + TL;
            if (state == DONE && taken)
                fillPtr <= ~fillPtr;
            for (int b = 0; b < 2; b++) begin
                if (state == CALC && fillPtr == 1'(b))
                    bankSt[b] <= FILLING;
                else if (state == DONE && taken && fillPtr == 1'(b))
                    bankSt[b] <= FULL;
                else if (bankRelease[b] && bankSt[b] == FULL)
                    bankSt[b] <= FREE;
            end
        end
    end

    always_comb begin
        offs = '0;
        unique case (issueCnt)
            2'd0: offs = '0;
            2'd1: offs = ADDRW'(winW);
            2'd2: offs = hoff;
            2'd3: offs = hoff + ADDRW'(winW);
            default: offs = '0;
        endcase
        ii_raddr = (state == ISSUE) ? base + offs : '0;
        sq_raddr = ii_raddr;
    end

    variance_corner_bank #(.IIDW(IIDW), .SQDW(SQDW)) bankA (
        .clk     (clk),
        .resetn  (resetn),
        .we      (wrEn && !fillPtr),
        .waddr   (wrIdx),
        .wdata   (ii_q),
        .wdataSQ (sq_q),
        .raddr   (vcrA_in.raddr),
        .raddrSQ (vcrA_in.raddrSQ),
        .q       (aQ),
        .qSQ     (aQSQ)
    );

    variance_corner_bank #(.IIDW(IIDW), .SQDW(SQDW)) bankB (
        .clk     (clk),
        .resetn  (resetn),
        .we      (wrEn && fillPtr),
        .waddr   (wrIdx),
        .wdata   (ii_q),
        .wdataSQ (sq_q),
        .raddr   (vcrB_in.raddr),
        .raddrSQ (vcrB_in.raddrSQ),
        .q       (bQ),
        .qSQ     (bQSQ)
    );

    assign vcrA_out.q   = aQ;
    assign vcrA_out.qSQ = aQSQ;
    assign vcrB_out.q   = bQ;
    assign vcrB_out.qSQ = bQSQ;

endmodule

// File: tb/tb_variance_corner_fetch.sv
// Scoreboard bench for variance_corner_fetch with an identity
// image memory (ii = addr, sq = 2*addr).
module tb_variance_corner_fetch;
    import structs::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        taken = 1'b0;
    logic [1:0]  bankRelease = 2'b00;
    logic [8:0]  win_x = '0, win_y = '0, win_w = '0, win_h = '0;
    logic        ready, valid, dblBuf, ii_rd;
    logic [16:0] ii_raddr, sq_raddr;
    logic [31:0] ii_q = '0;
    logic [63:0] sq_q = '0;
    struct_varianceCache_Read_in  vcrA_in = '0, vcrB_in = '0;
    struct_varianceCache_Read_out vcrA_out, vcrB_out;

    typedef struct packed {
        logic             bank;
        logic [3:0][31:0] q;
        logic [3:0][63:0] qSQ;
    } exp_t;

    exp_t sb[$];
    logic expBank = 1'b0;
    int   nTests = 0;
    int   nFail = 0;

    variance_corner_fetch dut (
        .clk(clk), .resetn(resetn), .start(start),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .ready(ready), .valid(valid), .dblBuf(dblBuf),
        .taken(taken), .bankRelease(bankRelease),
        .ii_raddr(ii_raddr), .sq_raddr(sq_raddr), .ii_rd(ii_rd),
        .ii_q(ii_q), .sq_q(sq_q),
        .vcrA_in(vcrA_in), .vcrB_in(vcrB_in),
        .vcrA_out(vcrA_out), .vcrB_out(vcrB_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ii_rd) begin
            ii_q <= 32'(ii_raddr);
            sq_q <= 64'(sq_raddr) * 64'd2;
        end
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pushExp(int x, int y, int w, int h);
        exp_t e;
        int   a[4];
        a[0] = y * 321 + x;
        a[1] = a[0] + w;
        a[2] = a[0] + h * 321;
        a[3] = a[2] + w;
        e.bank = expBank;
        for (int i = 0; i < 4; i++) begin
            e.q[i]   = 32'(a[i] & 'h1ffff);
            e.qSQ[i] = 64'(a[i] & 'h1ffff) * 64'd2;
        end
        sb.push_back(e);
    endtask

    task automatic readBank(input logic b, input logic [2:0] a,
                            input logic [2:0] aSQ,
                            output logic [31:0] q,
                            output logic [63:0] qs);
        if (b) begin
            vcrB_in.raddr = a;
            vcrB_in.raddrSQ = aSQ;
        end else begin
            vcrA_in.raddr = a;
            vcrA_in.raddrSQ = aSQ;
        end
        #1;
        q  = b ? vcrB_out.q : vcrA_out.q;
        qs = b ? vcrB_out.qSQ : vcrA_out.qSQ;
    endtask

    task automatic startWin(int x, int y, int w, int h, bit push);
        int n = 0;
        while (!ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready)
            chk("readyWait", 0, 1);
        win_x = 9'(x);
        win_y = 9'(y);
        win_w = 9'(w);
        win_h = 9'(h);
        start = 1'b1;
        if (push)
            pushExp(x, y, w, h);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called one step after the accepting edge (cycle 1).
    task automatic collect(int hold);
        int          lat = 1;
        int          rdCnt = 0;
        bit          stable = 1'b1;
        exp_t        e;
        logic [31:0] q;
        logic [63:0] qs;
        while (!valid && lat < 20) begin
            rdCnt += int'(ii_rd);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("valid", valid, 1);
        chk("latency", lat, 7);
        chk("rdCount", rdCnt, 4);
        if (sb.size() == 0) begin
            chk("sbEmpty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("dblBuf", dblBuf, e.bank);
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            if (!valid || dblBuf !== e.bank || ii_rd)
                stable = 1'b0;
        end
        start = 1'b0;
        if (hold > 0)
            chk("holdStable", stable, 1);
        for (int i = 0; i < 4; i++) begin
            readBank(e.bank, 3'(i + 1), 3'(i + 1), q, qs);
            chk("cornerQ", q, e.q[i]);
            chk("cornerQSQ", qs, e.qSQ[i]);
        end
        @(negedge clk);
        taken = 1'b1;
        @(posedge clk);
        #1;
        taken = 1'b0;
        expBank = ~expBank;
        chk("validDrop", valid, 0);
    endtask

    initial begin
        logic [31:0] q;
        logic [63:0] qs;

        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rstReady", ready, 1);
        @(posedge clk);
        #1;
        chk("rstValid", valid, 0);
        chk("rstDblBuf", dblBuf, 0);
        chk("rstRd", ii_rd, 0);
        chk("rstAddr", ii_raddr, 0);
        chk("rstAddrSQ", sq_raddr, 0);

        startWin(10, 20, 24, 24, 1);
        collect(0);

        startWin(3, 5, 7, 2, 1);
        collect(0);
        chk("fullNotReady", ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("fullStillNotReady", ready, 0);

        readBank(1'b0, 3'd0, 3'd7, q, qs);
        chk("rdA0", q, 0);
        chk("rdA7SQ", qs, 0);
        readBank(1'b1, 3'd7, 3'd0, q, qs);
        chk("rdB7", q, 0);
        chk("rdB0SQ", qs, 0);

        win_x = 9'd100;
        win_y = 9'd40;
        win_w = 9'd16;
        win_h = 9'd30;
        start = 1'b1;
        bankRelease = 2'b01;
        pushExp(100, 40, 16, 30);
        @(posedge clk);
        #1;
        bankRelease = 2'b00;
        chk("relStartReady", ready, 1);
        chk("relStartIgnored", ii_rd, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        collect(20);

        bankRelease = 2'b11;
        @(posedge clk);
        #1;
        bankRelease = 2'b00;
        chk("relBoth", ready, 1);

        startWin(50, 60, 8, 8, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("midIssue", ii_rd, 1);
        resetn = 1'b0;
        #1;
        chk("arstValid", valid, 0);
        chk("arstRd", ii_rd, 0);
        readBank(1'b0, 3'd1, 3'd1, q, qs);
        chk("arstA", q, 0);
        chk("arstASQ", qs, 0);
        readBank(1'b1, 3'd2, 3'd2, q, qs);
        chk("arstB", q, 0);
        chk("arstBSQ", qs, 0);
        @(negedge clk);
        resetn = 1'b1;
        expBank = 1'b0;
        @(posedge clk);
        #1;
        chk("arstReady", ready, 1);
        chk("arstDblBuf", dblBuf, 0);

        startWin(200, 100, 100, 120, 1);
        collect(0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
